// File: rtl/uart_tx_serializer_pkg.sv
// Shared types and helpers for the UART transmit serializer.
package uart_pkg;

    // Serializer FSM states, in frame order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } uart_tx_state_e;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    // Clocks per bit; truncating division, 0 when the baud rate is unusable.
    function automatic int calc_baud_div(input int clk_hz, input int baud);
        if (baud <= 0) begin
            return 0;
        end
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Bundle between the TX FIFO / control logic and the UART serializer.
//
// Handshake: the serializer raises fifo_rd_en for exactly one cycle, only
// while fifo_empty is low; the FIFO presents the popped byte on
// fifo_rd_data in the following cycle. There is no backpressure on the
// serializer side: tx_enable merely permits the start of the next frame.
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    import uart_pkg::*;

    logic                  tx_enable;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic                  tx;
    logic                  busy;
    logic                  frame_done;
    uart_tx_state_e        dbg_state;

    // Control / FIFO side.
    modport master (
        output tx_enable,
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  frame_done,
        input  dbg_state
    );

    // Serializer side.
    modport slave (
        input  tx_enable,
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd_en,
        output tx,
        output busy,
        output frame_done,
        output dbg_state
    );

endinterface

// File: rtl/uart_tx_serializer_baud_tick.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and flags the last clock of
// each bit period. Clearing restarts the period at count 0.
module uart_baud_tick #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_cnt == LAST_CNT);
    assign o_tick = w_tick;

    // Count up, wrapping to zero after the tick clock.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops bytes from the TX FIFO and sends each as
// start, data (LSB first), optional parity and stop bits on a registered
// tx line.
module uart_tx_serializer #(
    parameter int DATA_WIDTH  = 8,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD_RATE   = 115200,
    parameter int PARITY_EN   = 1,
    parameter int PARITY_ODD  = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_serializer_if.slave bus
);
    import uart_pkg::*;

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ_HZ, BAUD_RATE);
    localparam int IDX_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_W-1:0] LAST_DATA_IDX = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_STOP_IDX = IDX_W'(STOP_BITS - 1);

    // Reject configurations the frame logic cannot represent.
    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("uart_tx_serializer: BAUD_DIV must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
    end
    if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_parity_en
        $error("uart_tx_serializer: PARITY_EN must be 0 or 1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_data_width
        $error("uart_tx_serializer: DATA_WIDTH must be at least 1");
    end

    uart_tx_state_e        r_state;
    uart_tx_state_e        w_state_next;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  r_parity;
    logic                  w_parity_next;
    logic                  w_fetch_parity;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [IDX_W-1:0]      w_bit_idx_next;
    logic                  r_tx;
    logic                  w_tx_next;
    logic                  w_tick;
    logic                  w_baud_clear;
    logic                  w_rd_en;
    logic                  w_frame_done;

    // Each bit period starts at count 0 once the byte has been latched.
    assign w_baud_clear = (r_state == FETCH);

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_baud_clear),
        .o_tick  (w_tick)
    );

    // Pop only from IDLE, and never while reset is being applied.
    assign w_rd_en = (r_state == IDLE) && !rst && bus.tx_enable && !bus.fifo_empty;

    // Parity over the byte as it arrives from the FIFO.
    assign w_fetch_parity = (PARITY_ODD == uart_pkg::PARITY_ODD) ? ~(^bus.fifo_rd_data)
                                                                 :  (^bus.fifo_rd_data);

    // Next-state, shift register, bit index and frame-done decode.
    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_parity_next  = r_parity;
        w_bit_idx_next = r_bit_idx;
        w_frame_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rd_en) begin
                    w_state_next = FETCH;
                end
            end
            FETCH: begin
                w_shift_next   = bus.fifo_rd_data;
                w_parity_next  = w_fetch_parity;
                w_bit_idx_next = '0;
                w_state_next   = START;
            end
            START: begin
                if (w_tick) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_idx == LAST_DATA_IDX) begin
                        w_bit_idx_next = '0;
                        w_state_next   = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (w_tick) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_bit_idx == LAST_STOP_IDX) begin
                        w_frame_done   = 1'b1;
                        w_bit_idx_next = '0;
                        w_state_next   = IDLE;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, decoded from the next state so the
    // registered tx lines up exactly with the state it belongs to.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = w_shift_next[0];
            PARITY:  w_tx_next = w_parity_next;
            default: w_tx_next = 1'b1;
        endcase
    end

    // State, datapath and tx line registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_bit_idx <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_parity  <= w_parity_next;
            r_bit_idx <= w_bit_idx_next;
            r_tx      <= w_tx_next;
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.tx         = r_tx;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = w_frame_done;
    assign bus.dbg_state  = r_state;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit engine that sits directly downstream of the TX sync FIFO. It pops one byte at a time from the FIFO's registered read port. Each byte is serialised as start, data (LSB first), optional parity and stop bits onto the tx line at a fixed baud rate derived from a clock divider. It reports busy status and a per-frame completion pulse to the control/status logic.

Parameters:
DATA_WIDTH, 8, data bits per frame; must match the FIFO data width.
CLK_FREQ_HZ, 50_000_000, system clock frequency.
BAUD_RATE, 115200, line rate; BAUD_DIV = CLK_FREQ_HZ / BAUD_RATE (truncating integer division); default 434; elaboration error if BAUD_DIV < 2.
PARITY_EN, 1, 1 = append one parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
STOP_BITS, 1, 1 or 2; any other value is an elaboration error.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
tx_enable  input  1  gates the start of new frames only.
fifo_empty  input  1  empty flag from the TX FIFO.
fifo_rd_data  input  DATA_WIDTH  FIFO read data; registered in the FIFO, valid the cycle after a pop.
fifo_rd_en  output  1  one-cycle pop request to the FIFO.
tx  output  1  serial line; idle high; registered.
busy  output  1  high whenever state != IDLE.
frame_done  output  1  one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Reset (rst high at a clk edge): next cycle state = IDLE, tx = 1, busy = 0, fifo_rd_en = 0, frame_done = 0, baud counter = 0, bit index = 0. Reset mid-frame aborts the frame immediately with no further pop.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE, pop: fifo_rd_en = (state == IDLE) && tx_enable && !fifo_empty. This is combinational from the registered state. When it is asserted, the next state is FETCH. fifo_rd_en is never high while fifo_empty = 1 and is never high for more than one consecutive cycle.
- FETCH: lasts 1 cycle. Latch fifo_rd_data into the shift register, compute the parity bit, clear the baud counter, go to START.
- Per-bit timing: each of START, DATA bits, PARITY and STOP bits lasts exactly BAUD_DIV clocks. The baud counter runs 0..BAUD_DIV-1, and the tick is at BAUD_DIV-1.
- START: tx = 0.
- DATA: tx = shift_reg[0]; shift right on each tick. The bit index runs 0..DATA_WIDTH-1. After the last bit, go to PARITY if PARITY_EN = 1, otherwise go to STOP.
- PARITY: tx = ^data for even parity, ~^data for odd parity.
- STOP: tx = 1 for STOP_BITS*BAUD_DIV clocks. frame_done is asserted on the final clock, then the next state is IDLE.
- Latency: the pop cycle is N. The shift register is loaded at edge N+1. tx falls at the edge ending cycle N+1 (i.e. tx = 0 during cycle N+2).
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS)*BAUD_DIV clocks.
- Back-to-back frames: after STOP the FSM passes through IDLE (1 clk) and FETCH (1 clk). The inter-frame idle-high gap is therefore exactly 2 clocks beyond the stop bits.
- tx_enable dropped mid-frame: the current frame completes unchanged; no new pop occurs until tx_enable = 1.
- fifo_empty and fifo_rd_data are ignored outside IDLE and FETCH respectively.
- tx is driven from a register (glitch-free); next-state logic must not drive tx combinationally.

Decomposition:
- Package uart_pkg contains:
  - typedef enum logic [2:0] uart_tx_state_e {IDLE, FETCH, START, DATA, PARITY, STOP};
  - localparam PARITY_EVEN = 0, PARITY_ODD = 1;
  - function calc_baud_div(clk_hz, baud).
- One sub-module, uart_baud_tick: a counter with clear input and a tick output at BAUD_DIV-1, $clog2(BAUD_DIV) bits wide. It is cleared in FETCH and on rst.

Test Plan:
- Use a bench override of CLK_FREQ_HZ = 1600, BAUD_RATE = 100, giving BAUD_DIV = 16.
- Single byte 0xA5, PARITY_EN = 1, even parity, STOP_BITS = 1 -> one fifo_rd_en pulse. tx = 0 for 16 clks, then the bit sequence 1,0,1,0,0,1,0,1, then parity 0, then stop 1, each bit 16 clks. frame_done pulses at clock 176 after tx falls. busy drops the next cycle.
- Same byte 0xA5 with PARITY_ODD = 1 -> parity bit = 1. Frame length is still 11*16 = 176 clks.
- Three bytes 0x00, 0xFF, 0x3C pre-loaded, STOP_BITS = 2, PARITY_EN = 0 -> exactly three pops. Each frame is 11*16 clks. There are exactly 2 idle-high clks between frames. The bytes appear in FIFO order.
- fifo_empty = 1 and tx_enable = 1 for 100 clks -> fifo_rd_en never asserted; tx = 1, busy = 0 throughout.
- tx_enable dropped during the DATA bit 3 of byte 0x81 with a second byte queued -> 0x81 frame completes with the correct bits. No second pop occurs until tx_enable returns, and the pop then follows within 1 clk.
- rst pulsed mid-frame (during PARITY) -> tx = 1, busy = 0 and frame_done = 0 at the next cycle. No pop occurs while rst is high. The next frame starts cleanly with a full start bit.
